multicycle_ctrl_fsm: RTL and testbench

- Multicycle RV32I-subset control unit that sequences the shared datapath: PC, instruction register, memory port, register file, ALU and the immediate extender.
- Decodes opcode/funct3 from the instruction register and steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK states.
- Drives IMM_SRC so the extender produces the correct I/U/S/J/B immediate in every cycle where the ALU consumes it.
- Sits between the instruction register and all datapath mux selects and write enables.

---
 rtl/ctrl_pkg.sv | 86 ++++++++
 rtl/imm_src_dec.sv | 48 ++++
 rtl/multicycle_ctrl_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I-subset control unit.
// Holds the FSM state encoding, the extender select codes (also used by
// the immediate extender), opcode constants, datapath mux/ALU class codes
// and the DECODE-state dispatch function.
package ctrl_pkg;

    // FETCH is encoded as zero so the debug state output reads 0 in reset.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_EXEC_U   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_JALR     = 4'd12,
        S_JALR_PC  = 4'd13,
        S_JAL_LINK = 4'd14,
        S_ERROR    = 4'd15
    } state_t;

    // Immediate extender selects
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_U = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_B = 3'b100;

    // Supported opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // ALU A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Result select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // State that follows DECODE for a given opcode
    function automatic state_t decode_next(input logic [6:0] op);
        state_t nxt;
        case (op)
            OP_R:               nxt = S_EXEC_R;
            OP_I:               nxt = S_EXEC_I;
            OP_LOAD, OP_STORE:  nxt = S_MEM_ADDR;
            OP_BRANCH:          nxt = S_BRANCH;
            OP_JAL:             nxt = S_JAL;
            OP_JALR:            nxt = S_JALR;
            OP_LUI, OP_AUIPC:   nxt = S_EXEC_U;
            default:            nxt = S_ERROR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/imm_src_dec.sv
// Immediate-extender select decoder.
// Maps (state, opcode) to IMM_SRC so the extender output matches the
// immediate the ALU consumes in that cycle; 000 in every other state.
//   state_i   in  4  current control state
//   opcode_i  in  7  opcode from the instruction register
//   imm_src_o out 3  extender select
module imm_src_dec
    import ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_src_o
);

    state_t st_s;
    assign st_s = state_t'(state_i);

    // Extender select per state
    always_comb begin
        imm_src_o = IMM_I;
        case (st_s)
            S_DECODE: begin
                // Branch target / jump target is precomputed as oldPC + imm
                if (opcode_i == OP_BRANCH) begin
                    imm_src_o = IMM_B;
                end else if (opcode_i == OP_JAL) begin
                    imm_src_o = IMM_J;
                end else begin
                    imm_src_o = IMM_I;
                end
            end
            S_EXEC_I:   imm_src_o = IMM_I;
            S_EXEC_U:   imm_src_o = IMM_U;
            S_MEM_ADDR: begin
                if (opcode_i == OP_STORE) begin
                    imm_src_o = IMM_S;
                end else begin
                    imm_src_o = IMM_I;
                end
            end
            S_BRANCH:   imm_src_o = IMM_B;
            S_JAL:      imm_src_o = IMM_J;
            S_JALR:     imm_src_o = IMM_I;
            default:    imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I-subset control unit.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and
// drives every datapath mux select and write enable. Outputs are decoded
// from the state register and IR opcode; only the FETCH enables (mem_ready)
// and the BRANCH PC write (zero) are Mealy terms. All outputs are forced
// to 0 while rst_n is low.
//   clk, rst_n              clock, async active-low reset
//   opcode, funct3, zero    IR fields and ALU zero flag
//   mem_ready               memory handshake
//   PC_WE..RES_SRC          datapath enables and selects
//   illegal                 sticky unsupported-instruction flag
//   state                   current state (debug)
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            PC_WE,
    output logic            IR_WE,
    output logic            MEM_RE,
    output logic            MEM_WE,
    output logic            ADR_SRC,
    output logic            REG_WE,
    output logic [2:0]      IMM_SRC,
    output logic [1:0]      ALU_SRC_A,
    output logic [1:0]      ALU_SRC_B,
    output logic [1:0]      ALU_OP,
    output logic [1:0]      RES_SRC,
    output logic            illegal,
    output logic [ST_W-1:0] state
);

    state_t     state_q;
    logic       illegal_q;
    logic [2:0] imm_src_s;

    logic       pc_we_s, ir_we_s, mem_re_s, mem_we_s, adr_src_s, reg_we_s;
    logic [1:0] src_a_s, src_b_s, alu_op_s, res_src_s;

    imm_src_dec u_imm_src_dec (
        .state_i   (state_q),
        .opcode_i  (opcode),
        .imm_src_o (imm_src_s)
    );

    // State sequencing and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) state_q <= S_DECODE;
                    else           state_q <= S_FETCH;
                end
                S_DECODE: begin
                    state_q <= decode_next(opcode);
                    if (decode_next(opcode) == S_ERROR) illegal_q <= 1'b1;
                end
                S_EXEC_R, S_EXEC_I, S_EXEC_U, S_JAL: state_q <= S_ALU_WB;
                S_MEM_ADDR: begin
                    if (opcode == OP_STORE) begin
                        state_q <= S_MEM_WR;
                    end else if (opcode == OP_LOAD) begin
                        state_q <= S_MEM_RD;
                    end else begin
                        state_q   <= S_ERROR;
                        illegal_q <= 1'b1;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ready) state_q <= S_MEM_WB;
                    else           state_q <= S_MEM_RD;
                end
                S_MEM_WR: begin
                    if (mem_ready) state_q <= S_FETCH;
                    else           state_q <= S_MEM_WR;
                end
                S_MEM_WB, S_ALU_WB, S_JAL_LINK: state_q <= S_FETCH;
                S_BRANCH: begin
                    if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q   <= S_ERROR;
                        illegal_q <= 1'b1;
                    end
                end
                S_JALR:    state_q <= S_JALR_PC;
                S_JALR_PC: state_q <= S_JAL_LINK;
                S_ERROR: begin
                    state_q   <= S_ERROR;
                    illegal_q <= 1'b1;
                end
                default: begin
                    state_q   <= S_ERROR;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    // Per-state datapath controls; anything not set here stays 0
    always_comb begin
        pc_we_s   = 1'b0;
        ir_we_s   = 1'b0;
        mem_re_s  = 1'b0;
        mem_we_s  = 1'b0;
        adr_src_s = 1'b0;
        reg_we_s  = 1'b0;
        src_a_s   = 2'b00;
        src_b_s   = 2'b00;
        alu_op_s  = 2'b00;
        res_src_s = 2'b00;
        case (state_q)
            S_FETCH: begin
                // PC <= PC + 4 lands together with the instruction word
                mem_re_s  = 1'b1;
                ir_we_s   = mem_ready;
                pc_we_s   = mem_ready;
                src_a_s   = SRCA_PC;
                src_b_s   = SRCB_FOUR;
                alu_op_s  = ALUOP_ADD;
                res_src_s = RES_ALU;
            end
            S_DECODE: begin
                src_a_s  = SRCA_OLDPC;
                src_b_s  = SRCB_IMM;
                alu_op_s = ALUOP_ADD;
            end
            S_EXEC_R: begin
                src_a_s  = SRCA_RS1;
                src_b_s  = SRCB_RS2;
                alu_op_s = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                src_a_s  = SRCA_RS1;
                src_b_s  = SRCB_IMM;
                alu_op_s = ALUOP_FUNCT;
            end
            S_EXEC_U: begin
                if (opcode == OP_LUI) src_a_s = SRCA_ZERO;
                else                  src_a_s = SRCA_OLDPC;
                src_b_s  = SRCB_IMM;
                alu_op_s = ALUOP_ADD;
            end
            S_MEM_ADDR, S_JALR: begin
                src_a_s  = SRCA_RS1;
                src_b_s  = SRCB_IMM;
                alu_op_s = ALUOP_ADD;
            end
            S_MEM_RD: begin
                mem_re_s  = 1'b1;
                adr_src_s = 1'b1;
            end
            S_MEM_WR: begin
                mem_we_s  = 1'b1;
                adr_src_s = 1'b1;
            end
            S_MEM_WB: begin
                res_src_s = RES_MEM;
                reg_we_s  = 1'b1;
            end
            S_ALU_WB: begin
                res_src_s = RES_ALUOUT;
                reg_we_s  = 1'b1;
            end
            S_BRANCH: begin
                // ALUOut still holds the target computed in DECODE
                src_a_s   = SRCA_RS1;
                src_b_s   = SRCB_RS2;
                alu_op_s  = ALUOP_SUB;
                res_src_s = RES_ALUOUT;
                if (funct3 == F3_BEQ)      pc_we_s = zero;
                else if (funct3 == F3_BNE) pc_we_s = ~zero;
                else                       pc_we_s = 1'b0;
            end
            S_JAL: begin
                // Jump target from ALUOut while the ALU forms oldPC + 4 for the link
                src_a_s   = SRCA_OLDPC;
                src_b_s   = SRCB_FOUR;
                alu_op_s  = ALUOP_ADD;
                res_src_s = RES_ALUOUT;
                pc_we_s   = 1'b1;
            end
            S_JALR_PC: begin
                res_src_s = RES_ALUOUT;
                pc_we_s   = 1'b1;
            end
            S_JAL_LINK: begin
                src_a_s   = SRCA_OLDPC;
                src_b_s   = SRCB_FOUR;
                res_src_s = RES_ALU;
                reg_we_s  = 1'b1;
            end
            S_ERROR: begin
                pc_we_s = 1'b0;
            end
            default: begin
                pc_we_s = 1'b0;
            end
        endcase
    end

    // Every control output is held at 0 while reset is asserted
    assign PC_WE     = rst_n & pc_we_s;
    assign IR_WE     = rst_n & ir_we_s;
    assign MEM_RE    = rst_n & mem_re_s;
    assign MEM_WE    = rst_n & mem_we_s;
    assign ADR_SRC   = rst_n & adr_src_s;
    assign REG_WE    = rst_n & reg_we_s;
    assign IMM_SRC   = rst_n ? imm_src_s : 3'b000;
    assign ALU_SRC_A = rst_n ? src_a_s   : 2'b00;
    assign ALU_SRC_B = rst_n ? src_b_s   : 2'b00;
    assign ALU_OP    = rst_n ? alu_op_s  : 2'b00;
    assign RES_SRC   = rst_n ? res_src_s : 2'b00;
    assign illegal   = illegal_q;
    assign state     = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm. Each cycle the full output vector
// {PC_WE,IR_WE,MEM_RE,MEM_WE,ADR_SRC,REG_WE,IMM_SRC,ALU_SRC_A,ALU_SRC_B,
//  ALU_OP,RES_SRC,illegal,state} is compared against a hand-written value.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       PC_WE, IR_WE, MEM_RE, MEM_WE, ADR_SRC, REG_WE, illegal;
    logic [2:0] IMM_SRC;
    logic [1:0] ALU_SRC_A, ALU_SRC_B, ALU_OP, RES_SRC;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    multicycle_ctrl_fsm #(.ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .zero(zero), .mem_ready(mem_ready),
        .PC_WE(PC_WE), .IR_WE(IR_WE), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
        .ADR_SRC(ADR_SRC), .REG_WE(REG_WE), .IMM_SRC(IMM_SRC),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_OP(ALU_OP),
        .RES_SRC(RES_SRC), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Pack an expected output vector (same order as the observed one)
    function automatic logic [21:0] mk(
        input logic pc, input logic ir, input logic re, input logic we,
        input logic adr, input logic rwe, input logic [2:0] imm,
        input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
        input logic [1:0] res, input logic ill, input logic [3:0] st);
        return {pc, ir, re, we, adr, rwe, imm, a, b, op, res, ill, st};
    endfunction

    // Sample outputs mid-cycle, compare, then advance to 1 ns past the next rising edge
    task automatic cyc(input string tag, input logic [21:0] exp);
        logic [21:0] obs;
        @(negedge clk);
        obs = {PC_WE, IR_WE, MEM_RE, MEM_WE, ADR_SRC, REG_WE, IMM_SRC,
               ALU_SRC_A, ALU_SRC_B, ALU_OP, RES_SRC, illegal, state};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    logic [21:0] V_ZERO, V_FETCH, V_FWAIT, V_DEC_I, V_DEC_B, V_DEC_J;
    logic [21:0] V_MADDR_L, V_MADDR_S, V_MRD, V_MWR, V_MWB, V_AWB, V_ERR;

    // Branch instruction: FETCH, DECODE, BRANCH with the expected PC write
    task automatic run_branch(input string tag, input logic [2:0] f3,
                              input logic z, input logic exp_pc);
        opcode = 7'b1100011; funct3 = f3; zero = z; mem_ready = 1'b1;
        cyc({tag, "_fetch"}, V_FETCH);
        cyc({tag, "_decode"}, V_DEC_B);
        cyc({tag, "_branch"}, mk(exp_pc,1'b0,1'b0,1'b0,1'b0,1'b0,3'b100,
                                 2'b01,2'b00,2'b01,2'b00,1'b0,4'd10));
    endtask

    initial begin
        V_ZERO    = 22'd0;
        V_FETCH   = mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,3'b000,2'b00,2'b10,2'b00,2'b10,1'b0,4'd0);
        V_FWAIT   = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,3'b000,2'b00,2'b10,2'b00,2'b10,1'b0,4'd0);
        V_DEC_I   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,2'b10,2'b01,2'b00,2'b00,1'b0,4'd1);
        V_DEC_B   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b100,2'b10,2'b01,2'b00,2'b00,1'b0,4'd1);
        V_DEC_J   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b011,2'b10,2'b01,2'b00,2'b00,1'b0,4'd1);
        V_MADDR_L = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,2'b01,2'b01,2'b00,2'b00,1'b0,4'd5);
        V_MADDR_S = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b010,2'b01,2'b01,2'b00,2'b00,1'b0,4'd5);
        V_MRD     = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,3'b000,2'b00,2'b00,2'b00,2'b00,1'b0,4'd6);
        V_MWR     = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,3'b000,2'b00,2'b00,2'b00,2'b00,1'b0,4'd7);
        V_MWB     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'b000,2'b00,2'b00,2'b00,2'b01,1'b0,4'd8);
        V_AWB     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'b000,2'b00,2'b00,2'b00,2'b00,1'b0,4'd9);
        V_ERR     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,2'b00,2'b00,1'b1,4'd15);

        // Reset for two cycles with mem_ready high: everything 0
        rst_n = 1'b0; opcode = 7'b0000011; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        cyc("reset0", V_ZERO);
        cyc("reset1", V_ZERO);

        // Load with three wait cycles in MEM_RD: 8 cycles total
        rst_n = 1'b1;
        cyc("ld_fetch", V_FETCH);
        cyc("ld_decode", V_DEC_I);
        cyc("ld_maddr", V_MADDR_L);
        mem_ready = 1'b0;
        cyc("ld_mrd0", V_MRD);
        cyc("ld_mrd1", V_MRD);
        cyc("ld_mrd2", V_MRD);
        mem_ready = 1'b1;
        cyc("ld_mrd3", V_MRD);
        cyc("ld_mwb", V_MWB);

        // Store with zero-wait memory, back in FETCH after 4 cycles
        opcode = 7'b0100011;
        cyc("st_fetch", V_FETCH);
        cyc("st_decode", V_DEC_I);
        cyc("st_maddr", V_MADDR_S);
        cyc("st_mwr", V_MWR);

        // BEQ/BNE taken and not taken
        run_branch("beq_z1", 3'b000, 1'b1, 1'b1);
        run_branch("beq_z0", 3'b000, 1'b0, 1'b0);
        run_branch("bne_z1", 3'b001, 1'b1, 1'b0);
        run_branch("bne_z0", 3'b001, 1'b0, 1'b1);

        // JAL: target write then link writeback
        opcode = 7'b1101111;
        cyc("jal_fetch", V_FETCH);
        cyc("jal_decode", V_DEC_J);
        cyc("jal_jal", mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'b011,2'b10,2'b10,2'b00,2'b00,1'b0,4'd11));
        cyc("jal_awb", V_AWB);

        // LUI
        opcode = 7'b0110111;
        cyc("lui_fetch", V_FETCH);
        cyc("lui_decode", V_DEC_I);
        cyc("lui_execu", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b001,2'b11,2'b01,2'b00,2'b00,1'b0,4'd4));
        cyc("lui_awb", V_AWB);

        // AUIPC
        opcode = 7'b0010111;
        cyc("auipc_fetch", V_FETCH);
        cyc("auipc_decode", V_DEC_I);
        cyc("auipc_execu", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b001,2'b10,2'b01,2'b00,2'b00,1'b0,4'd4));
        cyc("auipc_awb", V_AWB);

        // R-type
        opcode = 7'b0110011;
        cyc("r_fetch", V_FETCH);
        cyc("r_decode", V_DEC_I);
        cyc("r_exec", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,2'b01,2'b00,2'b10,2'b00,1'b0,4'd2));
        cyc("r_awb", V_AWB);

        // I-type ALU
        opcode = 7'b0010011;
        cyc("i_fetch", V_FETCH);
        cyc("i_decode", V_DEC_I);
        cyc("i_exec", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,2'b01,2'b01,2'b10,2'b00,1'b0,4'd3));
        cyc("i_awb", V_AWB);

        // JALR: five cycles
        opcode = 7'b1100111;
        cyc("jalr_fetch", V_FETCH);
        cyc("jalr_decode", V_DEC_I);
        cyc("jalr_jalr", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,2'b01,2'b01,2'b00,2'b00,1'b0,4'd12));
        cyc("jalr_pc", mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,3'b000,2'b00,2'b00,2'b00,2'b00,1'b0,4'd13));
        cyc("jalr_link", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'b000,2'b10,2'b10,2'b00,2'b10,1'b0,4'd14));

        // FETCH waits while mem_ready is low
        opcode = 7'b0000011; mem_ready = 1'b0;
        cyc("fetch_wait", V_FWAIT);
        mem_ready = 1'b1;
        cyc("fetch_go", V_FETCH);
        cyc("fetch_go_decode", V_DEC_I);
        cyc("fetch_go_maddr", V_MADDR_L);
        cyc("fetch_go_mrd", V_MRD);
        cyc("fetch_go_mwb", V_MWB);

        // Unsupported branch funct3 traps to ERROR
        run_branch("b_f3_010", 3'b010, 1'b1, 1'b0);
        cyc("b_err0", V_ERR);
        cyc("b_err1", V_ERR);
        rst_n = 1'b0;
        cyc("b_err_reset", V_ZERO);

        // Illegal opcode: ERROR is absorbing with illegal held high
        rst_n = 1'b1; opcode = 7'b1111111;
        cyc("ill_fetch", V_FETCH);
        cyc("ill_decode", V_DEC_I);
        for (int i = 0; i < 11; i++) begin
            mem_ready = i[0];
            opcode = (i > 4) ? 7'b0110011 : 7'b1111111;
            cyc("ill_err", V_ERR);
        end
        rst_n = 1'b0;
        cyc("ill_reset", V_ZERO);

        // Reset in the middle of a MEM_RD wait aborts the load
        rst_n = 1'b1; opcode = 7'b0000011; mem_ready = 1'b1;
        cyc("ab_fetch", V_FETCH);
        cyc("ab_decode", V_DEC_I);
        cyc("ab_maddr", V_MADDR_L);
        mem_ready = 1'b0;
        cyc("ab_mrd", V_MRD);
        rst_n = 1'b0;
        cyc("ab_reset", V_ZERO);
        rst_n = 1'b1; mem_ready = 1'b1;
        cyc("ab_refetch", V_FETCH);
        cyc("ab_redecode", V_DEC_I);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
